serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin one subtraction; sampled on the clk rising edge.
REQ-005 Port a, input, WIDTH bits: minuend; sampled only on the edge where start is accepted.
REQ-006 Port b, input, WIDTH bits: subtrahend; sampled only on the edge where start is accepted.
REQ-007 Port busy, output, 1 bit: high while bit-serial processing is in progress.
REQ-008 Port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-009 Port diff, output, WIDTH bits: registered result of a minus b, modulo 2^WIDTH.
REQ-010 Port borrow_out, output, 1 bit: high when a is less than b as unsigned values.
REQ-011 Port overflow, output, 1 bit: signed two's-complement overflow of a minus b.

Function
REQ-012 The block SHALL compute a + ~b + 1 one bit per cycle, LSB first, through a single full-adder cell (sum = x^y^c, carry = x&y | c&(x^y)) with a registered carry.
REQ-013 The FSM SHALL have three states:
- IDLE: start=1 goes to SHIFT; otherwise stays in IDLE.
- SHIFT: stays in SHIFT until WIDTH bits are processed, then goes to DONE.
- DONE: unconditionally returns to IDLE after one cycle.
REQ-014 On the edge where start is accepted in IDLE, the block SHALL perform all of the following:
- load a and b into internal shift registers;
- clear the bit counter to 0;
- set the carry register to 1.
REQ-015 Each SHIFT cycle SHALL perform all of the following:
- consume bit 0 of the a and b shift registers;
- shift the sum bit into the MSB of the internal result register;
- update carry;
- increment the counter.
REQ-016 Exit from SHIFT SHALL occur on the edge where counter reaches WIDTH-1, i.e. after exactly WIDTH SHIFT cycles.
REQ-017 diff, borrow_out and overflow SHALL update only on the transition into DONE, and SHALL hold their values at all other times until the next result.
REQ-018 borrow_out SHALL equal the inverse of the final carry out of the MSB.
REQ-019 overflow SHALL equal (carry into the MSB) XOR (carry out of the MSB).
REQ-020 busy SHALL be 1 exactly in SHIFT.
REQ-021 done SHALL be 1 exactly in DONE.
REQ-022 Latency: done SHALL assert on the WIDTH+1-th rising edge after the start-accept edge.
REQ-023 start SHALL be ignored in SHIFT and DONE states; there is no queuing of requests.
REQ-024 Back-to-back operation: start held high SHALL be accepted again in the IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-025 Changes on a and b outside the accept edge SHALL NOT affect the result in progress.

Reset
REQ-026 When rst asserts, the block SHALL immediately, regardless of clk, force:
- state to IDLE;
- busy=0, done=0;
- diff=0, borrow_out=0, overflow=0;
- counter, shift registers and carry to 0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation, and no done pulse SHALL be produced for the aborted request.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first following rising edge.

Verification (WIDTH=8)
REQ-029 a=100, b=37, start pulsed for one cycle -> done on the 9th edge with diff=63, borrow_out=0, overflow=0; busy high for exactly 8 cycles.
REQ-030 a=37, b=100 -> diff=0xC1 (193), borrow_out=1, overflow=0.
REQ-031 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-032 a=0, b=0 -> diff=0, borrow_out=0, overflow=0; then a=0, b=1 -> diff=0xFF, borrow_out=1, overflow=0.
REQ-033 start with a=50, b=20, then start re-pulsed with a=9, b=9 during busy -> single done with diff=30; operands changed mid-SHIFT do not alter the result.
REQ-034 rst asserted asynchronously at the 4th SHIFT cycle -> outputs 0 immediately and no done; a fresh start then yields the correct result 9 edges later.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand request and result bundle for serial_subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow_out;
  logic overflow;
  modport master (output start, a, b, input busy, done, diff, borrow_out, overflow);
  modport slave (input start, a, b, output busy, done, diff, borrow_out, overflow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b (a + ~b + 1) through one full adder, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, res_n, diff_r;
  logic [WIDTH-2:0] res;
  logic [CW-1:0] cnt;
  logic carry, borrow_r, ovf_r, x, y, sum, cout, last;
  assign x = a_sr[0];
  assign y = ~b_sr[0];
  assign sum = x ^ y ^ carry;
  assign cout = (x & y) | (carry & (x ^ y));
  assign last = cnt == CW'(WIDTH - 1);
  assign res_n = {sum, res};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.start ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // carry entering the last cycle is the carry into the MSB, so overflow is carry ^ cout there
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      diff_r <= '0;
      borrow_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      cnt <= '0;
      carry <= 1'b1;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res <= res_n[WIDTH-1:1];
      carry <= cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff_r <= res_n;
        borrow_r <= ~cout;
        ovf_r <= carry ^ cout;
      end
    end
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  assign bus.diff = diff_r;
  assign bus.borrow_out = borrow_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [W-1:0] d;
    logic br;
    logic ov;
  } res_t;
  res_t q[$];
  res_t mon_e;
  int tests = 0;
  int fails = 0;
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b);
    res_t r;
    r.d = a - b;
    r.br = a < b;
    r.ov = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // every done pulse must match the oldest outstanding request
  always @(negedge clk)
    if (bus.done) begin
      chk("done_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("diff", 32'(bus.diff), 32'(mon_e.d));
        chk("borrow_out", 32'(bus.borrow_out), 32'(mon_e.br));
        chk("overflow", 32'(bus.overflow), 32'(mon_e.ov));
      end
    end
  // n counts edges with the accept edge as edge 1
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse);
    int n, nb;
    res_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    e = model(a, b);
    q.push_back(e);
    @(negedge clk);
    n = 1;
    nb = 0;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    while (!bus.done && n < 30) begin
      nb += int'(bus.busy);
      if (repulse && n == 3) begin
        bus.start = 1'b1;
        bus.a = 9;
        bus.b = 9;
      end else begin
        bus.start = 1'b0;
        bus.a = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk("latency", n, 9);
    chk("busy_cycles", nb, 8);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("diff_hold", 32'(bus.diff), 32'(e.d));
  endtask
  initial begin
    int n, first, second;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    run(8'd100, 8'd37, 1'b0);
    run(8'd37, 8'd100, 1'b0);
    run(8'h80, 8'h01, 1'b0);
    run(8'h7F, 8'hFF, 1'b0);
    run(8'd0, 8'd0, 1'b0);
    run(8'd0, 8'd1, 1'b0);
    run(8'd50, 8'd20, 1'b1);
    run(8'hA5, 8'h5A, 1'b0);
    // start held high: second request accepted in the IDLE cycle after DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd200;
    bus.b = 8'd55;
    q.push_back(model(8'd200, 8'd55));
    @(negedge clk);
    bus.a = 8'd3;
    bus.b = 8'd250;
    q.push_back(model(8'd3, 8'd250));
    n = 1;
    first = 0;
    second = 0;
    while (second == 0 && n < 40) begin
      if (bus.done) begin
        if (first == 0) first = n;
        else begin
          second = n;
          bus.start = 1'b0;
        end
      end
      if (second == 0) begin
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_first", first, 9);
    chk("b2b_period", second - first, 10);
    @(negedge clk);
    chk("b2b_no_third", 32'(bus.busy), 32'd0);
    // asynchronous reset in the 4th SHIFT cycle aborts without a done
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd77;
    bus.b = 8'd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    run(8'd120, 8'd7, 1'b0);
    run(8'd5, 8'd200, 1'b0);
    repeat (12) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
